// File: rtl/spu_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spu_rf_pkg
// Purpose  : Shared constants and types for the SPU multi-ported register file:
//            default geometry, read/write port numbering and the architectural
//            address/data typedefs.
// Revision : 1.0 - initial release
// ============================================================================
package spu_rf_pkg;

  // Default geometry
  localparam int c_NUM_REGS = 128;
  localparam int c_DATA_W   = 128;
  localparam int c_NUM_RD   = 5;
  localparam int c_NUM_WR   = 2;
  localparam int c_AW       = $clog2(c_NUM_REGS);

  // Read port numbering: even pipe ra/rb/rc, then odd pipe ra/rb
  localparam int c_RD_EVEN_A = 0;
  localparam int c_RD_EVEN_B = 1;
  localparam int c_RD_EVEN_C = 2;
  localparam int c_RD_ODD_A  = 3;
  localparam int c_RD_ODD_B  = 4;

  // Write port numbering: the odd port has priority on address collisions
  localparam int c_WR_EVEN = 0;
  localparam int c_WR_ODD  = 1;

  typedef logic [c_AW-1:0]     reg_addr_t;
  typedef logic [c_DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/spu_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : spu_regfile_mp_if
// Purpose  : Bundle of read, write and scoreboard-issue signals of the SPU
//            register file.
// Ports    : master modport drives rd_addr, wr_*, sb_set_*; samples rd_data,
//            rd_busy.  slave modport (the register file) is the reverse.
// Revision : 1.0 - initial release
// ============================================================================
interface spu_regfile_mp_if
  import spu_rf_pkg::*;
#(
  parameter int NUM_RD = c_NUM_RD,
  parameter int NUM_WR = c_NUM_WR,
  parameter int AW     = c_AW,
  parameter int DATA_W = c_DATA_W
);

  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;

  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][AW-1:0]     wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;

  logic [NUM_WR-1:0]             sb_set_en;
  logic [NUM_WR-1:0][AW-1:0]     sb_set_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data, rd_busy
  );

endinterface
`default_nettype wire

// File: rtl/spu_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : spu_rf_scoreboard
// Purpose  : One pending bit per architectural register.  An issue strobe
//            marks a register pending, a write-back clears it; when both hit
//            the same register in one cycle the issue wins (new producer).
// Ports    : clk, reset (async, active-low)
//            i_clr_en/i_clr_addr  - write-back strobes per write port
//            i_set_en/i_set_addr  - issue strobes per write port
//            o_pend_next          - pending vector as it will be after the edge
// Revision : 1.0 - initial release
// ============================================================================
module spu_rf_scoreboard
  import spu_rf_pkg::*;
#(
  parameter int NUM_REGS = c_NUM_REGS,
  parameter int NUM_WR   = c_NUM_WR,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WR-1:0]         i_clr_en,
  input  logic [NUM_WR-1:0][AW-1:0] i_clr_addr,
  input  logic [NUM_WR-1:0]         i_set_en,
  input  logic [NUM_WR-1:0][AW-1:0] i_set_addr,
  output logic [NUM_REGS-1:0]       o_pend_next
);

  localparam int          c_IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0] c_LIMIT = (AW+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] r_pend_q;
  logic [NUM_REGS-1:0] w_pend_d;

  // Clears are applied first so that a set to the same register overrides.
  always_comb begin
    w_pend_d = r_pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_clr_en[j] && ({1'b0, i_clr_addr[j]} < c_LIMIT)) begin
        w_pend_d[i_clr_addr[j][c_IW-1:0]] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_set_en[j] && ({1'b0, i_set_addr[j]} < c_LIMIT)) begin
        w_pend_d[i_set_addr[j][c_IW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_q <= '0;
    end else begin
      r_pend_q <= w_pend_d;
    end
  end

  assign o_pend_next = w_pend_d;

endmodule
`default_nettype wire

// File: rtl/spu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : spu_regfile_mp
// Purpose  : SPU multi-ported register file: NUM_RD registered read ports,
//            NUM_WR write ports (higher index wins on collisions) and a
//            pending-bit scoreboard reported per read port.
// Ports    : clk   - single clock, rising edge
//            reset - asynchronous, active-low
//            bus   - spu_regfile_mp_if.slave (read/write/issue signals)
// Options  : RF_BYPASS_EN - forward same-cycle winning write data to reads;
//            when undefined a same-cycle read returns the pre-write value.
// Revision : 1.0 - initial release
// ============================================================================
module spu_regfile_mp
  import spu_rf_pkg::*;
#(
  parameter int NUM_REGS = c_NUM_REGS,
  parameter int DATA_W   = c_DATA_W,
  parameter int NUM_RD   = c_NUM_RD,
  parameter int NUM_WR   = c_NUM_WR,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input logic             clk,
  input logic             reset,
  spu_regfile_mp_if.slave bus
);

  // AW may be wider than the index so that out-of-range addresses exist.
  localparam int          c_IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0] c_LIMIT = (AW+1)'(NUM_REGS);

  logic [DATA_W-1:0] r_mem_q [NUM_REGS];
  logic [DATA_W-1:0] w_mem_d [NUM_REGS];

  logic [NUM_WR-1:0] w_wr_ok;
  logic [NUM_RD-1:0] w_rd_ok;

  logic [NUM_REGS-1:0] w_pend_next;

  logic [NUM_RD-1:0][DATA_W-1:0] r_rd_data_q;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data_d;
  logic [NUM_RD-1:0]             r_rd_busy_q;
  logic [NUM_RD-1:0]             w_rd_busy_d;

  always_comb begin
    w_wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_wr_ok[j] = bus.wr_en[j] && ({1'b0, bus.wr_addr[j]} < c_LIMIT);
    end
    w_rd_ok = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_ok[i] = ({1'b0, bus.rd_addr[i]} < c_LIMIT);
    end
  end

  // Ascending port order: a later (higher-index) write overrides an earlier
  // one to the same register, so w_mem_d already holds the winning data.
  always_comb begin
    w_mem_d = r_mem_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (w_wr_ok[j]) begin
        w_mem_d[bus.wr_addr[j][c_IW-1:0]] = bus.wr_data[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_mem_q[r] <= '0;
      end
    end else begin
      r_mem_q <= w_mem_d;
    end
  end

  spu_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_clr_en    (bus.wr_en),
    .i_clr_addr  (bus.wr_addr),
    .i_set_en    (bus.sb_set_en),
    .i_set_addr  (bus.sb_set_addr),
    .o_pend_next (w_pend_next)
  );

  // Busy reports the post-edge pending state, so it is taken from the
  // scoreboard's next-state vector regardless of the bypass option.
  always_comb begin
    w_rd_data_d = '0;
    w_rd_busy_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_rd_ok[i]) begin
`ifdef RF_BYPASS_EN
        w_rd_data_d[i] = w_mem_d[bus.rd_addr[i][c_IW-1:0]];
`else
        w_rd_data_d[i] = r_mem_q[bus.rd_addr[i][c_IW-1:0]];
`endif
        w_rd_busy_d[i] = w_pend_next[bus.rd_addr[i][c_IW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data_q <= '0;
      r_rd_busy_q <= '0;
    end else begin
      r_rd_data_q <= w_rd_data_d;
      r_rd_busy_q <= w_rd_busy_d;
    end
  end

  assign bus.rd_data = r_rd_data_q;
  assign bus.rd_busy = r_rd_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_regfile_mp
// Purpose  : Self-checking bench for spu_regfile_mp (NUM_REGS=128, AW=8 so
//            that out-of-range addresses can be driven).  Stimulus pushes the
//            expected read-port result into a queue tagged with the cycle in
//            which it must be visible; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu_regfile_mp;
  import spu_rf_pkg::*;

  localparam int NR = 5;
  localparam int NW = 2;
  localparam int AWB = 8;
  localparam int DW = 128;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  spu_regfile_mp_if #(.NUM_RD(NR), .NUM_WR(NW), .AW(AWB), .DATA_W(DW)) bus ();

  spu_regfile_mp #(
    .NUM_REGS (128),
    .DATA_W   (DW),
    .NUM_RD   (NR),
    .NUM_WR   (NW),
    .AW       (AWB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        cyc;
    int        port;
    reg_data_t data;
    logic      busy;
    string     tag;
  } exp_t;

  exp_t sbq[$];

  task automatic push(input int c, input int p, input reg_data_t d, input logic b, input string t);
    exp_t e;
    e.cyc = c; e.port = p; e.data = d; e.busy = b; e.tag = t;
    sbq.push_back(e);
  endtask

  // Result visible after the next rising edge
  task automatic expect_rd(input int p, input reg_data_t d, input logic b, input string t);
    push(cyc + 1, p, d, b, t);
  endtask

  // Result must already be visible before the next rising edge
  task automatic expect_now(input int p, input reg_data_t d, input logic b, input string t);
    push(cyc, p, d, b, t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = '0;
    bus.sb_set_en = '0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      total++;
      if (bus.rd_data[e.port] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        bad++;
        $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                 e.tag, e.port, bus.rd_data[e.port], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  localparam reg_data_t D5 = {16'h000A, 112'h0};
  localparam reg_data_t PA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam reg_data_t PB = {4{32'hA5A5_5A5A}};

  initial begin : stim
    reset = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.sb_set_addr = '0;
    idle();

    // Reset state
    repeat (2) step();
    for (int i = 0; i < NR; i++) expect_now(i, '0, 1'b0, "rst_init");
    step();
    reset = 1'b1;

    // Write reg 5 on the even port at the first edge after release
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 8'd5; bus.wr_data[0] = D5;
    step();
    idle();
    for (int i = 0; i < NR; i++) bus.rd_addr[i] = 8'd5;
    for (int i = 0; i < NR; i++) expect_rd(i, D5, 1'b0, "rd_all5");
    step();
    step();

    // Asynchronous reset mid-run; write/set during reset is discarded
    reset = 1'b0;
    for (int i = 0; i < NR; i++) expect_now(i, '0, 1'b0, "rst_async");
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 8'd6; bus.wr_data[0] = PA;
    bus.sb_set_en[1] = 1'b1; bus.sb_set_addr[1] = 8'd6;
    step();
    step();
    idle();
    reset = 1'b1;
    bus.rd_addr[0] = 8'd5;
    bus.rd_addr[1] = 8'd6;
    expect_rd(0, '0, 1'b0, "rst_r5");
    expect_rd(1, '0, 1'b0, "rst_drop");
    step();

    // Both ports write reg 7: odd port wins
    bus.wr_en = 2'b11;
    bus.wr_addr[0] = 8'd7; bus.wr_data[0] = 128'd1;
    bus.wr_addr[1] = 8'd7; bus.wr_data[1] = 128'd2;
    step();
    idle();
    bus.rd_addr[0] = 8'd7;
    expect_rd(0, 128'd2, 1'b0, "wr_prio");
    step();

    // Distinct registers on both ports, read on different ports
    bus.wr_en = 2'b11;
    bus.wr_addr[0] = 8'd11; bus.wr_data[0] = PB;
    bus.wr_addr[1] = 8'd10; bus.wr_data[1] = PA;
    step();
    idle();
    bus.rd_addr[2] = 8'd10;
    bus.rd_addr[4] = 8'd11;
    expect_rd(2, PA, 1'b0, "rd_odd_wr");
    expect_rd(4, PB, 1'b0, "rd_even_wr");
    step();

    // Same-cycle write/read of reg 3
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 8'd3; bus.wr_data[0] = 128'h11;
    step();
    bus.wr_data[0] = 128'hFF;
    bus.rd_addr[1] = 8'd3;
    expect_rd(1, BYP ? 128'hFF : 128'h11, 1'b0, "bypass");
    step();
    idle();
    expect_rd(1, 128'hFF, 1'b0, "post_byp");
    step();

    // Scoreboard: set, clear by write, set+write same cycle
    bus.sb_set_en[0] = 1'b1; bus.sb_set_addr[0] = 8'd9;
    step();
    idle();
    bus.rd_addr[0] = 8'd9;
    bus.rd_addr[3] = 8'd9;
    expect_rd(0, '0, 1'b1, "sb_set");
    expect_rd(3, '0, 1'b1, "sb_set_odd");
    step();
    bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 8'd9; bus.wr_data[1] = 128'h99;
    expect_rd(0, BYP ? 128'h99 : 128'h0, 1'b0, "sb_clr");
    step();
    idle();
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 8'd9; bus.wr_data[0] = 128'h77;
    bus.sb_set_en[1] = 1'b1; bus.sb_set_addr[1] = 8'd9;
    expect_rd(0, BYP ? 128'h77 : 128'h99, 1'b1, "sb_setclr");
    step();
    idle();
    expect_rd(0, 128'h77, 1'b1, "sb_hold");
    step();

    // Out-of-range address 200 (aliases to 72 in the low 7 bits)
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 8'd200; bus.wr_data[0] = 128'hDEAD;
    bus.sb_set_en[0] = 1'b1; bus.sb_set_addr[0] = 8'd200;
    bus.rd_addr[0] = 8'd200;
    bus.rd_addr[1] = 8'd72;
    expect_rd(0, '0, 1'b0, "oor_rd");
    expect_rd(1, '0, 1'b0, "oor_alias_pre");
    step();
    idle();
    expect_rd(0, '0, 1'b0, "oor_rd2");
    expect_rd(1, '0, 1'b0, "oor_alias");
    step();

    // Top register boundary
    bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 8'd127; bus.wr_data[1] = PA;
    step();
    idle();
    bus.rd_addr[2] = 8'd127;
    expect_rd(2, PA, 1'b0, "reg127");
    step();

    repeat (3) step();
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d unchecked entries, want 0", sbq.size());
      total += sbq.size();
      bad += sbq.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spu_regfile_mp.md
SPU_REGFILE_MP -- requirements
Module: spu_regfile_mp

Interface
REQ-001 Parameter NUM_REGS, default 128, number of architectural registers.
REQ-002 Parameter DATA_W, default 128, register width in bits.
REQ-003 Parameter NUM_RD, default 5, number of read ports: even ra/rb/rc plus odd ra/rb.
REQ-004 Parameter NUM_WR, default 2, number of write ports: even, odd.
REQ-005 Derived constant AW = $clog2(NUM_REGS).
REQ-006 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-low reset.
REQ-008 Port rd_addr, input, NUM_RD x AW, read address per read port.
REQ-009 Port rd_data, output, NUM_RD x DATA_W, registered read data per read port.
REQ-010 Port rd_busy, output, NUM_RD, registered pending flag of the register read on each port.
REQ-011 Port wr_en, input, NUM_WR, write strobe per write port.
REQ-012 Port wr_addr, input, NUM_WR x AW, destination register per write port.
REQ-013 Port wr_data, input, NUM_WR x DATA_W, write value per write port.
REQ-014 Port sb_set_en, input, NUM_WR, issue strobe that marks a destination register pending.
REQ-015 Port sb_set_addr, input, NUM_WR x AW, register to mark pending.

Function
REQ-016 Writes SHALL commit at the rising clk edge in which wr_en[j]=1.
REQ-017 When two write ports target the same address in one cycle, the higher-index port SHALL win.
REQ-018 Reads SHALL have 1-cycle latency: rd_data[i] after edge k SHALL equal the register value selected by rd_addr[i] at edge k.
REQ-019 A write to register r SHALL clear the pending bit of r at the same edge.
REQ-020 sb_set_en[j] SHALL set the pending bit of sb_set_addr[j].
REQ-021 A set and a clear of the same register in one cycle SHALL leave the bit set, because the new producer wins.
REQ-022 rd_busy[i] SHALL equal the post-edge pending bit of the register sampled by rd_addr[i].
REQ-023 Out-of-range addresses (at or above NUM_REGS) SHALL be ignored for writes and sets; reads of them SHALL return zero with busy 0.
REQ-024 Read ports SHALL be fully independent; any number of ports may read the same address in one cycle.

Reset
REQ-025 When reset=0, all registers, rd_data, rd_busy and pending bits SHALL clear to 0 immediately, without waiting for clk.
REQ-026 Writes and sets presented while reset=0 SHALL be discarded.
REQ-027 The first edge after reset deasserts SHALL operate normally.

Configuration
REQ-028 Macro RF_BYPASS_EN, when defined, SHALL forward same-cycle write data to the read path: if rd_addr[i] matches a winning write, rd_data[i] SHALL show that wr_data.
REQ-029 Without RF_BYPASS_EN, a same-cycle read SHALL return the pre-write value.
REQ-030 rd_busy SHALL follow REQ-022 in both configurations.

Structure
REQ-031 Package spu_rf_pkg SHALL hold the default parameter constants, the reg_addr_t and reg_data_t typedefs, and the port-count constants.
REQ-032 The pending-bit logic SHALL be a sub-module spu_rf_scoreboard, parametrised on NUM_REGS and NUM_WR.
REQ-033 The storage array SHALL remain in spu_regfile_mp.

Verification
REQ-034 Reset low mid-run after writing reg 5 -> all rd_data 0 and rd_busy 0 immediately; a read of reg 5 after release returns 0.
REQ-035 Write reg 5 = 128'h000A_0000...0 on the even port, read reg 5 on all 5 ports next cycle -> all ports return 128'h000A_0000...0 one cycle later.
REQ-036 Even and odd ports write reg 7 with 1 and 2 in the same cycle -> reg 7 reads 2.
REQ-037 Write reg 3 = 0xFF while reading reg 3 in the same cycle -> rd_data is 0xFF with RF_BYPASS_EN, and the old value without it.
REQ-038 sb_set reg 9, then read reg 9 -> rd_busy 1; write reg 9 -> busy 0; set and write reg 9 in the same cycle -> busy 1.
REQ-039 Write to address 200 with NUM_REGS=128 and AW=8 -> no register changes; a read of 200 returns 0.
